// File: rtl/lcd_bus_monitor.sv
// HD44780-style bus responder: decodes lcd_driver writes into a 2x16 shadow
// display with an indexed, registered read port.
module lcd_bus_monitor #(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] BLANK_CHAR   = 8'h20,
  parameter int         CLEAR_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_index,
  output logic [7:0] rd_char,
  output logic [6:0] cur_addr,
  output logic       display_on,
  output logic       busy,
  output logic       frame_done,
  output logic [1:0] err_flags
);

  localparam int CNT_W = $clog2(CLEAR_CYCLES + 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] clr_cnt;
  logic             clr_wr;

  logic [10:0] sync_p0 [SYNC_STAGES];
  logic [10:0] cmd_p1;
  logic        vld_p1;
  logic        cmd_rs, cmd_rw;
  logic [7:0]  cmd_data;

  logic [7:0]  shadow [32];
  logic        id;

  logic        wr_en, clr_req, frame_nxt, id_nxt, disp_nxt;
  logic [4:0]  wr_idx;
  logic [6:0]  addr_nxt;
  logic [1:0]  err_nxt;

  // Only 0x00-0x0F and 0x40-0x4F are visible; bit 6 selects the line.
  function automatic logic addr_in_range(input logic [6:0] a);
    return (a[5:4] == 2'b00);
  endfunction

  function automatic logic [4:0] addr_to_index(input logic [6:0] a);
    return {a[6], a[3:0]};
  endfunction

  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a == 7'h27) return 7'h40;
      if (a == 7'h67) return 7'h00;
      return a + 7'd1;
    end
    if (a == 7'h40) return 7'h27;
    if (a == 7'h00) return 7'h67;
    return a - 7'd1;
  endfunction

  // Stage p0: input synchronizers, packed as {rs, rw, e, data}
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p0[i] <= '0;
      cmd_p1 <= '0;
    end else begin
      sync_p0[0] <= {lcd_rs, lcd_rw, lcd_e, lcd_data};
      for (int i = 1; i < SYNC_STAGES; i++) sync_p0[i] <= sync_p0[i-1];
      cmd_p1 <= sync_p0[SYNC_STAGES-1];
    end
  end

  // Stage p1: falling edge of synced E; command fields held from while E was high
  assign vld_p1   = cmd_p1[8] & ~sync_p0[SYNC_STAGES-1][8];
  assign cmd_rs   = cmd_p1[10];
  assign cmd_rw   = cmd_p1[9];
  assign cmd_data = cmd_p1[7:0];

  always_comb begin
    wr_en     = 1'b0;
    wr_idx    = addr_to_index(cur_addr);
    addr_nxt  = cur_addr;
    id_nxt    = id;
    disp_nxt  = display_on;
    err_nxt   = err_flags;
    clr_req   = 1'b0;
    frame_nxt = 1'b0;
    if (vld_p1) begin
      if (state == CLEAR) begin
        err_nxt[1] = 1'b1;
      end else if (cmd_rw) begin
        err_nxt[0] = 1'b1;
      end else if (cmd_rs) begin
        wr_en     = addr_in_range(cur_addr);
        frame_nxt = wr_en && (wr_idx == 5'd31);
        addr_nxt  = step_addr(cur_addr, id);
      end else begin
        casez (cmd_data)
          8'b1???????: addr_nxt = cmd_data[6:0];
          8'b01??????, 8'b001?????, 8'b0001????: ;
          8'b00001???: disp_nxt = cmd_data[2];
          8'b000001??: id_nxt = cmd_data[1];
          8'b0000001?: addr_nxt = '0;
          8'b00000001: begin
            addr_nxt = '0;
            id_nxt   = 1'b1;
            clr_req  = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_req) state_nxt = CLEAR;
      CLEAR:   if (clr_cnt == CNT_W'(CLEAR_CYCLES - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == CLEAR);
    clr_wr = busy && (clr_cnt < CNT_W'(32));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               clr_cnt <= '0;
    else if (state == CLEAR) clr_cnt <= clr_cnt + CNT_W'(1);
    else                    clr_cnt <= '0;
  end

  // Stage p2: shadow, address counter and registered read port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) shadow[i] <= BLANK_CHAR;
      cur_addr   <= '0;
      id         <= 1'b1;
      display_on <= 1'b0;
      err_flags  <= '0;
      frame_done <= 1'b0;
      rd_char    <= BLANK_CHAR;
    end else begin
      cur_addr   <= addr_nxt;
      id         <= id_nxt;
      display_on <= disp_nxt;
      err_flags  <= err_nxt;
      frame_done <= frame_nxt;
      rd_char    <= shadow[rd_index];
      if (wr_en)  shadow[wr_idx] <= cmd_data;
      if (clr_wr) shadow[clr_cnt[4:0]] <= BLANK_CHAR;
    end
  end

endmodule
